pulse_width_meter: RTL and testbench
====================================

Name: pulse_width_meter

Overview:
- Synthesizable measurement stage for a level-type `start` strobe.
- Counts the clock edges on which `start` is sampled high and reports the width once per pulse when `start` drops.
- Also keeps running statistics: pulse count, minimum and maximum width, and runt/overflow flags.
- Sits directly downstream of the `start` generator. Its `width` output is the RTL counterpart of the `$rose(start) |-> (start,count++)[*1:$] ##1 !start` check, so benches can compare the two.

Parameters:
- CNT_W, 8: width of the width counter and of the width/min/max outputs.
- MIN_W, 1: minimum accepted pulse width in cycles; shorter pulses are runts. Legal range 1..2^CNT_W-1.
- NPULSE_W, 16: width of the accepted-pulse counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  measured signal, synchronous to clk.
- clear_stats  in  1  synchronous clear of pulse_cnt, min_width and max_width.
- width  out  CNT_W  width of the last accepted pulse, in clock edges.
- width_valid  out  1  one-cycle strobe: width updated.
- overflow  out  1  qualifies width_valid: pulse exceeded 2^CNT_W-1 cycles.
- runt  out  1  one-cycle strobe: pulse shorter than MIN_W was dropped.
- busy  out  1  high while a pulse is being measured.
- pulse_cnt  out  NPULSE_W  number of accepted pulses; wraps modulo 2^NPULSE_W.
- min_width  out  CNT_W  smallest accepted width since reset or clear.
- max_width  out  CNT_W  largest accepted width since reset or clear.

Behaviour:
- Reset values (synchronous, when rst sampled 1):
  - state = IDLE, internal counter = 0.
  - width = 0, width_valid = 0, overflow = 0, runt = 0, busy = 0.
  - pulse_cnt = 0, max_width = 0, min_width = all-ones.
- An in-flight pulse is discarded on reset; no strobe is issued.
- FSM, 2 states:
  - IDLE: if start = 1, go to MEAS and set cnt = 1.
  - MEAS, start = 1: cnt = cnt + 1, saturating at 2^CNT_W-1; set the sticky ovf bit when an increment is attempted at saturation.
  - MEAS, start = 0: go to IDLE and evaluate the pulse.
- Rising-edge semantics:
  - The first edge sampled high after reset counts as a rise, so `start` held high through reset release is measured from the first post-reset edge.
  - width = number of posedges sampling start = 1, including the first.
- Evaluation at the edge sampling start = 0 (registered outputs, visible after that edge):
  - cnt >= MIN_W: width = cnt, width_valid = 1 for exactly one cycle, overflow = ovf, pulse_cnt += 1.
  - On that acceptance, max_width = max(max_width, cnt) and min_width = min(min_width, cnt).
  - cnt < MIN_W: runt = 1 for one cycle; width and statistics unchanged.
- Latency: strobe asserted the cycle after the first low sample, i.e. W+1 edges after the first high sample.
- Back-to-back pulses:
  - A single low sample separates pulses; the next high sample starts a new measurement immediately from IDLE.
  - The strobe for pulse N and the counting of pulse N+1 overlap legally.
- busy = 1 exactly while the state is MEAS.
- clear_stats:
  - Takes priority over an evaluation in the same cycle: the stats are cleared and that pulse's statistics update is lost.
  - width and width_valid still update normally.
- Overflow: width reports 2^CNT_W-1 (saturated) with overflow = 1; min and max use the saturated value.
- width holds its last value until the next accepted pulse.

Decomposition:
- Package pwm_meas_pkg: state enum (IDLE, MEAS) and a CNT_SAT constant function of CNT_W.
- No sub-module is needed. An optional edge/level sampler is not required because the input is already synchronous.

Test Plan:
- rst released with start = 1, start dropped after 12 edges -> width = 12, width_valid = 1 for one cycle on the 13th edge, pulse_cnt = 1, min_width = max_width = 12.
- Pulses of 5, 1 and 9 with one low cycle between each, MIN_W = 1 -> three strobes with widths 5, 1, 9; min_width = 1, max_width = 9, pulse_cnt = 3.
- MIN_W = 3, pulses of 2 then 4 -> runt strobe for the first pulse only; width = 4 with width_valid; pulse_cnt = 1.
- CNT_W = 4, pulse of 20 cycles -> width = 15, overflow = 1 with width_valid; max_width = 15.
- rst asserted on the 6th cycle of a pulse -> no width_valid or runt strobe; all outputs at reset values; a following 3-cycle pulse reports width = 3.
- clear_stats asserted on the same edge as an evaluation of width 7 -> width = 7 with width_valid; pulse_cnt = 0, max_width = 0, min_width = all-ones.

Source files
------------

// File: rtl/pwm_meas_pkg.sv
// Shared definitions for the pulse width meter.
//   state_e : measurement FSM state (IDLE, MEAS)
//   cnt_sat : saturation value (all-ones) of a counter of the given width
package pwm_meas_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_e;

  function automatic int cnt_sat(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/pulse_width_meter.sv
// Pulse width meter: counts the clock edges on which start is sampled high
// and reports the width once per pulse when start drops, plus running
// statistics over accepted pulses.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : measured level, already synchronous to clk
//   clear_stats  : clears pulse_cnt / min_width / max_width
//   width        : width of the last accepted pulse (saturates at all-ones)
//   width_valid  : one-cycle strobe, width updated
//   overflow     : qualifies width_valid, pulse ran past the saturation value
//   runt         : one-cycle strobe, pulse shorter than MIN_W was dropped
//   busy         : high while a pulse is being measured
//   pulse_cnt    : accepted-pulse count, wraps
//   min_width    : smallest accepted width since reset/clear
//   max_width    : largest accepted width since reset/clear
//
// state | meaning
// IDLE  | waiting for start to be sampled high
// MEAS  | counting edges with start high
module pulse_width_meter
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MIN_W    = 1,
  parameter int NPULSE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                clear_stats,
  output logic [CNT_W-1:0]    width,
  output logic                width_valid,
  output logic                overflow,
  output logic                runt,
  output logic                busy,
  output logic [NPULSE_W-1:0] pulse_cnt,
  output logic [CNT_W-1:0]    min_width,
  output logic [CNT_W-1:0]    max_width
);

  localparam logic [CNT_W-1:0] CntSat = CNT_W'(cnt_sat(CNT_W));
  localparam logic [CNT_W-1:0] MinW   = CNT_W'(MIN_W);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_q;
  logic [CNT_W-1:0]      width_q;
  logic                  width_valid_q;
  logic                  overflow_q;
  logic                  runt_q;
  logic                  busy_q;
  logic [NPULSE_W-1:0]   pulse_cnt_q;
  logic [CNT_W-1:0]      min_q;
  logic [CNT_W-1:0]      max_q;

  logic                  cnt_at_sat;
  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      min_d;
  logic [CNT_W-1:0]      max_d;

  always_comb begin
    cnt_at_sat = (cnt_q == CntSat);
    cnt_d      = cnt_at_sat ? cnt_q : cnt_q + CNT_W'(1);
    min_d      = (cnt_q < min_q) ? cnt_q : min_q;
    max_d      = (cnt_q > max_q) ? cnt_q : max_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      width_q       <= '0;
      width_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      runt_q        <= 1'b0;
      busy_q        <= 1'b0;
      pulse_cnt_q   <= '0;
      min_q         <= '1;
      max_q         <= '0;
    end else begin
      width_valid_q <= 1'b0;
      runt_q        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= MEAS;
            cnt_q   <= CNT_W'(1);
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        MEAS: begin
          if (start) begin
            cnt_q <= cnt_d;
            // an increment attempted at saturation marks the pulse as overflowed
            if (cnt_at_sat) ovf_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (cnt_q >= MinW) begin
              width_q       <= cnt_q;
              width_valid_q <= 1'b1;
              overflow_q    <= ovf_q;
              if (!clear_stats) begin
                pulse_cnt_q <= pulse_cnt_q + NPULSE_W'(1);
                min_q       <= min_d;
                max_q       <= max_d;
              end
            end else begin
              runt_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // clear wins over a same-cycle statistics update
      if (clear_stats) begin
        pulse_cnt_q <= '0;
        min_q       <= '1;
        max_q       <= '0;
      end
    end
  end

  assign width       = width_q;
  assign width_valid = width_valid_q;
  assign overflow    = overflow_q;
  assign runt        = runt_q;
  assign busy        = busy_q;
  assign pulse_cnt   = pulse_cnt_q;
  assign min_width   = min_q;
  assign max_width   = max_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
module tb_pulse_width_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic clear_stats = 1'b0;

  always #5 clk = ~clk;

  // instance 0: CNT_W=8 MIN_W=1, instance 1: CNT_W=8 MIN_W=3, instance 2: CNT_W=4 MIN_W=1
  logic [7:0]  w0, w1, mn0, mn1, mx0, mx1;
  logic [3:0]  w2, mn2, mx2;
  logic [15:0] pc0, pc1, pc2;
  logic        wv0, wv1, wv2, ov0, ov1, ov2, rn0, rn1, rn2, bz0, bz1, bz2;

  pulse_width_meter #(.CNT_W(8), .MIN_W(1), .NPULSE_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .clear_stats(clear_stats),
    .width(w0), .width_valid(wv0), .overflow(ov0), .runt(rn0), .busy(bz0),
    .pulse_cnt(pc0), .min_width(mn0), .max_width(mx0));

  pulse_width_meter #(.CNT_W(8), .MIN_W(3), .NPULSE_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .clear_stats(clear_stats),
    .width(w1), .width_valid(wv1), .overflow(ov1), .runt(rn1), .busy(bz1),
    .pulse_cnt(pc1), .min_width(mn1), .max_width(mx1));

  pulse_width_meter #(.CNT_W(4), .MIN_W(1), .NPULSE_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .clear_stats(clear_stats),
    .width(w2), .width_valid(wv2), .overflow(ov2), .runt(rn2), .busy(bz2),
    .pulse_cnt(pc2), .min_width(mn2), .max_width(mx2));

  int a_width[3], a_pcnt[3], a_min[3], a_max[3];
  bit a_wv[3], a_ovf[3], a_runt[3], a_busy[3];

  always_comb begin
    a_width[0] = int'(w0);  a_width[1] = int'(w1);  a_width[2] = int'(w2);
    a_pcnt[0]  = int'(pc0); a_pcnt[1]  = int'(pc1); a_pcnt[2]  = int'(pc2);
    a_min[0]   = int'(mn0); a_min[1]   = int'(mn1); a_min[2]   = int'(mn2);
    a_max[0]   = int'(mx0); a_max[1]   = int'(mx1); a_max[2]   = int'(mx2);
    a_wv[0]    = wv0;       a_wv[1]    = wv1;       a_wv[2]    = wv2;
    a_ovf[0]   = ov0;       a_ovf[1]   = ov1;       a_ovf[2]   = ov2;
    a_runt[0]  = rn0;       a_runt[1]  = rn1;       a_runt[2]  = rn2;
    a_busy[0]  = bz0;       a_busy[1]  = bz1;       a_busy[2]  = bz2;
  end

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Behavioural model: a pulse is a run of high samples of unbounded length;
  // when the run ends its width is the run length clipped to the counter range.
  int sat[3]  = '{255, 255, 15};
  int minw[3] = '{1, 3, 1};
  int m_len[3], m_width[3], m_pcnt[3], m_min[3], m_max[3];
  bit m_wv[3], m_ovf[3], m_runt[3], m_busy[3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_len[k] = 0; m_width[k] = 0; m_wv[k] = 0; m_ovf[k] = 0; m_runt[k] = 0;
        m_busy[k] = 0; m_pcnt[k] = 0; m_max[k] = 0; m_min[k] = sat[k];
      end else begin
        m_wv[k]   = 0;
        m_runt[k] = 0;
        if (start) begin
          m_len[k]++;
          m_busy[k] = 1;
        end else if (m_len[k] > 0) begin
          int w;
          w = (m_len[k] < sat[k]) ? m_len[k] : sat[k];
          if (m_len[k] >= minw[k]) begin
            m_width[k] = w;
            m_wv[k]    = 1;
            m_ovf[k]   = (m_len[k] > sat[k]);
            m_pcnt[k]  = (m_pcnt[k] + 1) % 65536;
            if (w > m_max[k]) m_max[k] = w;
            if (w < m_min[k]) m_min[k] = w;
          end else begin
            m_runt[k] = 1;
          end
          m_len[k]  = 0;
          m_busy[k] = 0;
        end
        if (clear_stats) begin
          m_pcnt[k] = 0; m_max[k] = 0; m_min[k] = sat[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        chk("width", k, a_width[k], m_width[k]);
        chk("width_valid", k, int'(a_wv[k]), int'(m_wv[k]));
        chk("runt", k, int'(a_runt[k]), int'(m_runt[k]));
        chk("busy", k, int'(a_busy[k]), int'(m_busy[k]));
        chk("pulse_cnt", k, a_pcnt[k], m_pcnt[k]);
        chk("min_width", k, a_min[k], m_min[k]);
        chk("max_width", k, a_max[k], m_max[k]);
        if (m_wv[k]) chk("overflow", k, int'(a_ovf[k]), int'(m_ovf[k]));
      end
    end
  end

  int n_wv[3], n_runt[3];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (a_wv[k] === 1'b1) n_wv[k]++;
      if (a_runt[k] === 1'b1) n_runt[k]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input int n);
    start = 1'b1;
    repeat (n) tick();
    start = 1'b0;
    tick();
  endtask

  int s_wv0, s_rn0, s_wv1, s_rn1;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    armed = 1'b1;
    chk("rst_width", 0, int'(w0), 0);
    chk("rst_min", 2, int'(mn2), 15);

    // start held high through reset release, 12 high edges
    start = 1'b1;
    rst   = 1'b0;
    repeat (12) tick();
    chk("t1_no_strobe_yet", 0, int'(wv0), 0);
    start = 1'b0;
    tick();
    chk("t1_width", 0, int'(w0), 12);
    chk("t1_wv", 0, int'(wv0), 1);
    chk("t1_pcnt", 0, int'(pc0), 1);
    chk("t1_min", 0, int'(mn0), 12);
    chk("t1_max", 0, int'(mx0), 12);
    tick();
    chk("t1_wv_one_cycle", 0, int'(wv0), 0);
    tick();

    // back-to-back 5, 1, 9
    do_reset();
    s_wv0 = n_wv[0]; s_rn1 = n_runt[1];
    pulse(5); pulse(1); pulse(9);
    chk("t2_width", 0, int'(w0), 9);
    chk("t2_pcnt", 0, int'(pc0), 3);
    chk("t2_min", 0, int'(mn0), 1);
    chk("t2_max", 0, int'(mx0), 9);
    chk("t2_m3_pcnt", 1, int'(pc1), 2);
    tick(); tick();
    chk("t2_strobes", 0, n_wv[0] - s_wv0, 3);
    chk("t2_m3_runts", 1, n_runt[1] - s_rn1, 1);

    // MIN_W=3: 2 is a runt, 4 is accepted
    do_reset();
    s_wv1 = n_wv[1]; s_rn1 = n_runt[1];
    pulse(2);
    chk("t3_runt", 1, int'(rn1), 1);
    chk("t3_width_held", 1, int'(w1), 0);
    pulse(4);
    chk("t3_width", 1, int'(w1), 4);
    chk("t3_wv", 1, int'(wv1), 1);
    chk("t3_pcnt", 1, int'(pc1), 1);
    tick(); tick();
    chk("t3_strobes", 1, n_wv[1] - s_wv1, 1);
    chk("t3_runts", 1, n_runt[1] - s_rn1, 1);

    // overflow on the 4-bit instance, 15 exactly is not an overflow
    do_reset();
    pulse(20);
    chk("t4_width", 2, int'(w2), 15);
    chk("t4_ovf", 2, int'(ov2), 1);
    chk("t4_wv", 2, int'(wv2), 1);
    chk("t4_max", 2, int'(mx2), 15);
    chk("t4_w8", 0, int'(w0), 20);
    chk("t4_ovf8", 0, int'(ov0), 0);
    tick();
    pulse(15);
    chk("t4_sat_exact_ovf", 2, int'(ov2), 0);
    chk("t4_sat_exact_w", 2, int'(w2), 15);
    pulse(16);
    chk("t4_sat_plus1_ovf", 2, int'(ov2), 1);
    tick(); tick();

    // reset on the 6th cycle of a pulse
    do_reset();
    s_wv0 = n_wv[0]; s_rn0 = n_runt[0];
    start = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("t5_width", 0, int'(w0), 0);
    chk("t5_busy", 0, int'(bz0), 0);
    chk("t5_ovf", 0, int'(ov0), 0);
    chk("t5_pcnt", 0, int'(pc0), 0);
    chk("t5_min", 0, int'(mn0), 255);
    chk("t5_max", 0, int'(mx0), 0);
    tick();
    chk("t5_no_wv", 0, n_wv[0] - s_wv0, 0);
    chk("t5_no_runt", 0, n_runt[0] - s_rn0, 0);
    pulse(3);
    chk("t5_width_after", 0, int'(w0), 3);
    tick(); tick();

    // clear_stats on the evaluation edge of a 7-wide pulse
    do_reset();
    pulse(4);
    start = 1'b1;
    repeat (7) tick();
    start       = 1'b0;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("t6_width", 0, int'(w0), 7);
    chk("t6_wv", 0, int'(wv0), 1);
    chk("t6_pcnt", 0, int'(pc0), 0);
    chk("t6_max", 0, int'(mx0), 0);
    chk("t6_min", 0, int'(mn0), 255);
    chk("t6_min4", 2, int'(mn2), 15);
    tick(); tick();

    // pure clear_stats while idle
    pulse(6);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("t7_pcnt", 0, int'(pc0), 0);
    chk("t7_width_kept", 0, int'(w0), 6);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
